// File: rtl/fb_write_ctrl.sv
// -----------------------------------------------------------------------------
// fb_write_ctrl
//   Buffers the pixel generator's stream in a small FIFO and drains it as
//   writes into a double-buffered RGB333 framebuffer. A toggle on pix_swap marks
//   the end of a frame; the front/back bank flip is deferred until every pixel
//   queued ahead of that toggle has been accepted by the memory.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   pix_valid/data/addr   incoming pixel (addr = y*640+x, passed unchecked)
//   pix_swap              level that toggles once per completed frame
//   mem_wr_en/addr/wdata  write request to the single-port framebuffer;
//                         mem_addr = {write_bank, pixel address}
//   mem_ready             write accepted when mem_wr_en & mem_ready
//   disp_bank             bank the scan-out stage must read (always ~write_bank)
//   frame_done            one-cycle pulse on each bank flip
//   overflow              sticky, set when an entry is dropped on a full FIFO
//   fifo_level            current FIFO occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module fb_write_ctrl #(
  parameter int DATA_W     = 9,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pix_valid,
  input  logic [DATA_W-1:0]               pix_data,
  input  logic [ADDR_W-1:0]               pix_addr,
  input  logic                            pix_swap,
  output logic                            mem_wr_en,
  output logic [ADDR_W:0]                 mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic                            mem_ready,
  output logic                            disp_bank,
  output logic                            frame_done,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // Entry layout: {has_pix, has_swap, data, addr}
  localparam int ENT_W = 2 + DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLIP  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               swap_q, swap_armed;
  logic               swap_ev, push_req, push, pop;
  logic               full, empty;
  logic               write_bank, hold_swap;
  logic               load, stop, flip;
  logic [ENT_W-1:0]   head;
  logic               head_pix, head_swap;
  logic [DATA_W-1:0]  head_data;
  logic [ADDR_W-1:0]  head_addr;

  // swap_q takes pix_swap on the first clock after reset release, so the
  // initial level of pix_swap never reads as a frame boundary.
  assign swap_ev  = swap_armed & (pix_swap != swap_q);
  assign push_req = pix_valid | swap_ev;
  assign full     = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty    = (fifo_level == LVL_W'(0));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req & (~full | pop);

  assign head      = fifo_mem[rd_ptr];
  assign head_pix  = head[ENT_W-1];
  assign head_swap = head[ENT_W-2];
  assign head_data = head[ADDR_W +: DATA_W];
  assign head_addr = head[ADDR_W-1:0];

  // Swap toggle edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_q     <= 1'b0;
      swap_armed <= 1'b0;
    end else begin
      swap_q     <= pix_swap;
      swap_armed <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pix_valid, swap_ev, pix_data, pix_addr};
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= PTR_W'(0);
      rd_ptr     <= PTR_W'(0);
      fifo_level <= LVL_W'(0);
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (push_req && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: pop decisions and datapath strobes.
  //   load : head pixel goes into the mem_* output registers
  //   stop : drop mem_wr_en
  //   flip : swap banks this edge
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    stop     = 1'b0;
    flip     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_pix) begin
            load     = 1'b1;
            state_nx = WRITE;
          end else begin
            state_nx = FLIP;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          if (hold_swap) begin
            // The accepted pixel closed the frame.
            stop     = 1'b1;
            state_nx = FLIP;
          end else if (!empty) begin
            pop = 1'b1;
            if (head_pix) begin
              load     = 1'b1;
              state_nx = WRITE;
            end else begin
              // Swap-only entry right behind the last pixel.
              stop     = 1'b1;
              state_nx = FLIP;
            end
          end else begin
            stop     = 1'b1;
            state_nx = IDLE;
          end
        end else begin
          state_nx = WRITE;
        end
      end
      FLIP: begin
        flip     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Memory write port registers and bank bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hold_swap  <= 1'b0;
      write_bank <= 1'b1;
      disp_bank  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        mem_wr_en <= 1'b1;
        mem_addr  <= {write_bank, head_addr};
        mem_wdata <= head_data;
        hold_swap <= head_swap;
      end else if (stop) begin
        mem_wr_en <= 1'b0;
      end
      if (flip) begin
        write_bank <= ~write_bank;
        disp_bank  <= ~disp_bank;
      end
      frame_done <= flip;
    end
  end

endmodule
